// File: rtl/axi_addr_ch_tx.sv
// AXI address channel transmitter: buffers translated AR/AW commands in a FIFO
// and presents them through a registered VALID/READY output stage.
module axi_addr_ch_tx #(
  parameter int BUF_SZ = 64
) (
  input  logic                      tx_clk,
  input  logic                      reset_,
  input  logic [3:0]                in_id,
  input  logic [31:0]               in_addr,
  input  logic [7:0]                in_len,
  input  logic [2:0]                in_size,
  input  logic [1:0]                in_burst,
  input  logic [2:0]                in_prot,
  input  logic [3:0]                in_cache,
  input  logic [1:0]                in_user,
  input  logic                      in_lock,
  input  logic                      i_buf_wr,
  output logic                      o_buf_full,
  output logic [$clog2(BUF_SZ):0]   o_buf_count,
  output logic [3:0]                out_id,
  output logic [31:0]               out_addr,
  output logic [7:0]                out_len,
  output logic [2:0]                out_size,
  output logic [1:0]                out_burst,
  output logic [2:0]                out_prot,
  output logic [3:0]                out_cache,
  output logic [1:0]                out_user,
  output logic                      out_lock,
  output logic                      out_valid,
  input  logic                      in_ready,
  output logic                      o_ovf,
  output logic [31:0]               o_txn_cnt
);

  localparam int AW = $clog2(BUF_SZ);

  typedef struct packed {
    logic        lock;
    logic [1:0]  user;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [31:0] addr;
    logic [3:0]  id;
  } cmd_t;

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  cmd_t          mem [BUF_SZ];
  cmd_t          in_cmd;
  cmd_t          out_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  state_t        state;
  state_t        state_nxt;
  logic          push;
  logic          pop;
  logic          fifo_nempty;

  assign in_cmd = '{lock: in_lock, user: in_user, cache: in_cache, prot: in_prot,
                    burst: in_burst, size: in_size, len: in_len, addr: in_addr, id: in_id};

  // Fullness looks only at the current occupancy, so a same-cycle pop never frees a slot.
  assign o_buf_full  = (count == (AW+1)'(BUF_SZ));
  assign fifo_nempty = (count != '0);
  assign push        = i_buf_wr & ~o_buf_full;

  // NOTE: always_comb assigns every output a default first so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (fifo_nempty) begin
          pop       = 1'b1;
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (in_ready) begin
          if (fifo_nempty) pop = 1'b1;
          else             state_nxt = ST_EMPTY;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // NOTE: the storage array has no reset; pointers and count alone define which entries are live.
  always_ff @(posedge tx_clk) begin
    if (push) mem[wr_ptr] <= in_cmd;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge tx_clk) begin
    if (!reset_) begin
      state     <= ST_EMPTY;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_q     <= '0;
      o_ovf     <= 1'b0;
      o_txn_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      if (pop) begin
        rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
        out_q  <= mem[rd_ptr];
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (i_buf_wr && o_buf_full) o_ovf <= 1'b1;
      if (out_valid && in_ready)  o_txn_cnt <= o_txn_cnt + 32'd1;
    end
  end

  // VALID is a pure state decode, never a combinational function of READY.
  assign out_valid   = (state == ST_FULL);
  assign o_buf_count = count;
  assign out_id      = out_q.id;
  assign out_addr    = out_q.addr;
  assign out_len     = out_q.len;
  assign out_size    = out_q.size;
  assign out_burst   = out_q.burst;
  assign out_prot    = out_q.prot;
  assign out_cache   = out_q.cache;
  assign out_user    = out_q.user;
  assign out_lock    = out_q.lock;

endmodule

// File: tb/tb_axi_addr_ch_tx.sv
// Scoreboard bench for axi_addr_ch_tx: an occupancy model predicts status outputs,
// accepted commands queue up and are matched against the output channel in order.
module tb_axi_addr_ch_tx;

  localparam int BUF_SZ = 16;
  localparam int CW     = $clog2(BUF_SZ);

  typedef struct packed {
    logic        lock;
    logic [1:0]  user;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [31:0] addr;
    logic [3:0]  id;
  } cmd_t;

  logic        tx_clk = 1'b0;
  logic        reset_ = 1'b0;
  cmd_t        cur_cmd = '0;
  logic        i_buf_wr = 1'b0;
  logic        in_ready = 1'b0;
  logic        o_buf_full;
  logic [CW:0] o_buf_count;
  logic [3:0]  out_id;
  logic [31:0] out_addr;
  logic [7:0]  out_len;
  logic [2:0]  out_size;
  logic [1:0]  out_burst;
  logic [2:0]  out_prot;
  logic [3:0]  out_cache;
  logic [1:0]  out_user;
  logic        out_lock;
  logic        out_valid;
  logic        o_ovf;
  logic [31:0] o_txn_cnt;

  always #5 tx_clk = ~tx_clk;

  axi_addr_ch_tx #(.BUF_SZ(BUF_SZ)) dut (
    .tx_clk(tx_clk), .reset_(reset_),
    .in_id(cur_cmd.id), .in_addr(cur_cmd.addr), .in_len(cur_cmd.len), .in_size(cur_cmd.size),
    .in_burst(cur_cmd.burst), .in_prot(cur_cmd.prot), .in_cache(cur_cmd.cache),
    .in_user(cur_cmd.user), .in_lock(cur_cmd.lock),
    .i_buf_wr(i_buf_wr), .o_buf_full(o_buf_full), .o_buf_count(o_buf_count),
    .out_id(out_id), .out_addr(out_addr), .out_len(out_len), .out_size(out_size),
    .out_burst(out_burst), .out_prot(out_prot), .out_cache(out_cache), .out_user(out_user),
    .out_lock(out_lock), .out_valid(out_valid), .in_ready(in_ready),
    .o_ovf(o_ovf), .o_txn_cnt(o_txn_cnt)
  );

  cmd_t dut_cmd;
  assign dut_cmd = '{lock: out_lock, user: out_user, cache: out_cache, prot: out_prot,
                     burst: out_burst, size: out_size, len: out_len, addr: out_addr, id: out_id};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO occupancy, presented-slot flag and counters; exp_q holds every
  // accepted command not yet handshaken, oldest first.
  cmd_t        exp_q[$];
  int          m_cnt   = 0;
  bit          m_valid = 1'b0;
  bit          m_ovf   = 1'b0;
  logic [31:0] m_txn   = '0;
  bit          mon_en  = 1'b0;

  always @(posedge tx_clk) begin
    bit hs, do_pop, do_push;
    if (!reset_) begin
      m_cnt = 0; m_valid = 1'b0; m_ovf = 1'b0; m_txn = '0;
      exp_q.delete();
    end else begin
      hs      = m_valid && (in_ready === 1'b1);
      do_pop  = (m_cnt > 0) && (!m_valid || (in_ready === 1'b1));
      do_push = (i_buf_wr === 1'b1) && (m_cnt < BUF_SZ);
      if ((i_buf_wr === 1'b1) && !do_push) m_ovf = 1'b1;
      if (hs) m_txn = m_txn + 32'd1;
      m_cnt = m_cnt + int'(do_push) - int'(do_pop);
      if (do_pop)  m_valid = 1'b1;
      else if (hs) m_valid = 1'b0;
      if (do_push) exp_q.push_back(cur_cmd);
    end
  end

  // Monitor: status compared every cycle; the presented command must be the oldest pending one.
  always @(negedge tx_clk) begin
    if (mon_en) begin
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("buf_count", 64'(o_buf_count), 64'(m_cnt));
      check("buf_full", 64'(o_buf_full), 64'(m_cnt == BUF_SZ));
      check("ovf", 64'(o_ovf), 64'(m_ovf));
      check("txn_cnt", 64'(o_txn_cnt), 64'(m_txn));
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL extra_cmd: got 0x%0h expected none at %0t", dut_cmd, $time);
        end else begin
          check("cmd_fields", 64'(dut_cmd), 64'(exp_q[0]));
          if (in_ready === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic cmd_t rand_cmd();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[58:0];
  endfunction

  // Inputs change just after the active edge and are sampled at the following one.
  task automatic step(input bit wr, input bit rdy, input cmd_t c);
    @(posedge tx_clk); #1;
    i_buf_wr = wr; in_ready = rdy; cur_cmd = c;
  endtask

  task automatic do_reset();
    @(posedge tx_clk); #1;
    reset_ = 1'b0; i_buf_wr = 1'b0; in_ready = 1'b0;
    @(posedge tx_clk); #1;
    reset_ = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * BUF_SZ + 8 && (m_cnt != 0 || m_valid); i++) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    @(negedge tx_clk);
    check("drain_idle", 64'(m_cnt != 0 || m_valid), 64'd0);
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    cmd_t c;
    // Reset values
    repeat (2) @(posedge tx_clk);
    #1 reset_ = 1'b1;
    mon_en = 1'b1;
    @(negedge tx_clk);
    check("rst_fields", 64'(dut_cmd), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);

    // Single command with exact latency: push at E0, VALID after E1, gone after E2
    c = rand_cmd(); c.addr = 32'h1000_0040; c.id = 4'd3; c.len = 8'd7;
    step(1'b1, 1'b1, c);
    step(1'b0, 1'b1, '0);
    @(negedge tx_clk); check("lat_e0_valid", 64'(out_valid), 64'd0);
    step(1'b0, 1'b1, '0);
    @(negedge tx_clk); check("lat_e1_valid", 64'(out_valid), 64'd1);
    check("lat_e1_addr", 64'(out_addr), 64'h1000_0040);
    step(1'b0, 1'b1, '0);
    @(negedge tx_clk); check("lat_e2_valid", 64'(out_valid), 64'd0);
    check("lat_txn", 64'(o_txn_cnt), 64'd1);

    // Backpressure: three commands held behind READY=0
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rand_cmd());
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
    @(negedge tx_clk); check("bp_count", 64'(o_buf_count), 64'd2);
    drain();

    // Fill past capacity with READY=0
    for (int i = 0; i < BUF_SZ + 2; i++) step(1'b1, 1'b0, rand_cmd());
    step(1'b0, 1'b0, '0);
    @(negedge tx_clk);
    check("fill_full", 64'(o_buf_full), 64'd1);
    check("fill_ovf", 64'(o_ovf), 64'd1);
    check("fill_count", 64'(o_buf_count), 64'(BUF_SZ));
    drain();

    // Push into a full FIFO while a pop happens in the same cycle
    do_reset();
    for (int i = 0; i < BUF_SZ + 1; i++) step(1'b1, 1'b0, rand_cmd());
    step(1'b1, 1'b1, rand_cmd());
    step(1'b0, 1'b0, '0);
    @(negedge tx_clk);
    check("fullpop_count", 64'(o_buf_count), 64'(BUF_SZ - 1));
    check("fullpop_ovf", 64'(o_ovf), 64'd1);
    drain();

    // Streaming: continuous push and READY with incrementing addresses
    for (int i = 0; i < 200; i++) begin
      c = rand_cmd(); c.addr = 32'h2000_0000 + 32'(i * 4);
      step(1'b1, 1'b1, c);
    end
    drain();

    // Random traffic
    for (int i = 0; i < 600; i++) step(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 45), rand_cmd());
    drain();

    // Reset in the middle of a stalled burst
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, rand_cmd());
    @(negedge tx_clk); check("mid_valid_pre", 64'(out_valid), 64'd1);
    do_reset();
    @(negedge tx_clk);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_count", 64'(o_buf_count), 64'd0);
    check("mid_rst_ovf", 64'(o_ovf), 64'd0);
    check("mid_rst_txn", 64'(o_txn_cnt), 64'd0);
    drain();

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
